// File: rtl/cap_state_sequencer_if.sv
// Request channel of the cap-bank sequencer: requested bank state with a
// valid/ready handshake.
interface cap_state_sequencer_if;
  logic [3:0] req_state;
  logic       req_valid;
  logic       req_ready;

  modport master (
    output req_state,
    output req_valid,
    input  req_ready
  );

  modport slave (
    input  req_state,
    input  req_valid,
    output req_ready
  );
endinterface

// File: rtl/cap_state_sequencer.sv
// Drive square-wave generator plus break-before-make sequencer for the 4-bit
// cap-bank state word; every non-emergency state change lands on a falling edge.
module cap_state_sequencer #(
  parameter int unsigned ClkDiv      = 8,
  parameter int unsigned DeadPeriods = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  cap_state_sequencer_if.slave   req,
  input  logic                   all_off,
  output logic                   clk500khz,
  output logic [3:0]             state,
  output logic                   busy
);

  localparam int unsigned DivW  = (ClkDiv > 2) ? $clog2(ClkDiv) : 1;
  localparam int unsigned DeadW = (DeadPeriods > 1) ? $clog2(DeadPeriods) : 1;
  localparam logic [DivW-1:0]  DivLast  = DivW'(ClkDiv - 1);
  localparam logic [DeadW-1:0] DeadInit = DeadW'(DeadPeriods - 1);

  typedef enum logic [1:0] {StIdle, StDrop, StDead, StAdd} st_e;

  st_e              st_q, st_d;
  logic [DivW-1:0]  div_cnt_q, div_cnt_d;
  logic             clk_q, clk_d;
  logic [3:0]       state_q, state_d;
  logic [3:0]       target_q, target_d;
  logic [DeadW-1:0] dead_cnt_q, dead_cnt_d;
  logic             fall_tick;
  logic             accept;

  // Divider free-runs regardless of all_off.
  always_comb begin
    div_cnt_d = div_cnt_q + DivW'(1);
    clk_d     = clk_q;
    if (div_cnt_q == DivLast) begin
      div_cnt_d = '0;
      clk_d     = ~clk_q;
    end
  end

  assign fall_tick = (div_cnt_q == DivLast) && clk_q;

  // Ready is gated by rst_n so nothing can be accepted while held in reset.
  assign req.req_ready = rst_n && (st_q == StIdle) && !all_off;
  assign accept        = req.req_valid && req.req_ready;

  always_comb begin
    st_d       = st_q;
    state_d    = state_q;
    target_d   = target_q;
    dead_cnt_d = dead_cnt_q;

    if (all_off) begin
      st_d     = StIdle;
      state_d  = '0;
      target_d = '0;
    end else begin
      unique case (st_q)
        StIdle: begin
          if (accept) begin
            target_d = req.req_state;
            if (req.req_state == state_q) begin
              st_d = StIdle;
            end else if ((state_q & ~req.req_state) == 4'b0000) begin
              st_d = StAdd;
            end else begin
              st_d = StDrop;
            end
          end
        end
        StDrop: begin
          if (fall_tick) begin
            state_d    = state_q & target_q;
            dead_cnt_d = DeadInit;
            st_d       = ((target_q & ~state_q) == 4'b0000) ? StIdle : StDead;
          end
        end
        StDead: begin
          if (fall_tick) begin
            if (dead_cnt_q == '0) begin
              state_d = target_q;
              st_d    = StIdle;
            end else begin
              dead_cnt_d = dead_cnt_q - DeadW'(1);
            end
          end
        end
        StAdd: begin
          if (fall_tick) begin
            state_d = target_q;
            st_d    = StIdle;
          end
        end
        default: st_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q       <= StIdle;
      div_cnt_q  <= '0;
      clk_q      <= 1'b0;
      state_q    <= '0;
      target_q   <= '0;
      dead_cnt_q <= '0;
    end else begin
      st_q       <= st_d;
      div_cnt_q  <= div_cnt_d;
      clk_q      <= clk_d;
      state_q    <= state_d;
      target_q   <= target_d;
      dead_cnt_q <= dead_cnt_d;
    end
  end

  assign clk500khz = clk_q;
  assign state     = state_q;
  assign busy      = (st_q != StIdle);

endmodule

// File: tb/tb_cap_state_sequencer.sv
// Scoreboard bench: stimulus pushes expected state changes, a negedge monitor
// pops and checks value, busy, edge alignment, latency and drop-to-add gap.
module tb_cap_state_sequencer;

  typedef struct {
    logic [3:0] st;
    logic       busy;
    bit         align;
    int         max_lat;
    int         gap;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       all_off = 1'b0;
  logic       clk500khz;
  logic [3:0] state;
  logic       busy;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   mark_cyc = 0;
  int   last_chg_cyc = 0;
  exp_t exp_q[$];

  logic [3:0] prev_state = 4'b0000;
  logic       prev_clk = 1'b0;

  cap_state_sequencer_if bus ();

  cap_state_sequencer #(
    .ClkDiv      (4),
    .DeadPeriods (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (bus),
    .all_off   (all_off),
    .clk500khz (clk500khz),
    .state     (state),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every change of the state word must match the head of the queue.
  always @(negedge clk) begin
    exp_t e;
    if (state !== prev_state) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_change", {28'd0, state}, {28'd0, prev_state});
      end else begin
        e = exp_q.pop_front();
        chk("state_value", {28'd0, state}, {28'd0, e.st});
        chk("busy_after_change", {31'd0, busy}, {31'd0, e.busy});
        if (e.align)
          chk("falling_edge_aligned", {31'd0, (prev_clk === 1'b1) && (clk500khz === 1'b0)}, 1);
        if (e.max_lat != 0)
          chk("latency_in_range",
              {31'd0, ((cyc - mark_cyc) >= 1) && ((cyc - mark_cyc) <= e.max_lat)}, 1);
        if (e.gap != 0)
          chk("drop_add_gap", cyc - last_chg_cyc, e.gap);
      end
      last_chg_cyc = cyc;
    end
    prev_state = state;
    prev_clk   = clk500khz;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] st, input logic b, input bit al, input int ml,
                      input int gp);
    exp_t e;
    e.st = st; e.busy = b; e.align = al; e.max_lat = ml; e.gap = gp;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [3:0] v, input logic exp_busy);
    int n = 0;
    step();
    while (bus.req_ready !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    chk("ready_before_send", {31'd0, bus.req_ready}, 1);
    bus.req_state = v;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    mark_cyc      = cyc;
    bus.req_valid = 1'b0;
    step();
    chk("busy_after_accept", {31'd0, busy}, {31'd0, exp_busy});
  endtask

  // Waits for expected changes to be consumed; optionally also for busy to drop.
  task automatic drain(input bit need_idle);
    int n = 0;
    while ((exp_q.size() != 0 || (need_idle && busy)) && n < 100) begin
      if (busy) chk("ready_low_while_busy", {31'd0, bus.req_ready}, 0);
      step();
      n++;
    end
    chk("drain_in_time", exp_q.size(), 0);
    if (need_idle) chk("idle_after_drain", {31'd0, busy}, 0);
  endtask

  initial begin
    bus.req_state = 4'b0000;
    bus.req_valid = 1'b0;

    repeat (3) step();
    chk("rst_ready", {31'd0, bus.req_ready}, 0);
    chk("rst_clk", {31'd0, clk500khz}, 0);
    chk("rst_state", {28'd0, state}, 0);
    chk("rst_busy", {31'd0, busy}, 0);

    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      step();
      chk("div_after_reset", {31'd0, clk500khz}, (n / 4) % 2);
    end
    chk("idle_state", {28'd0, state}, 0);
    chk("idle_busy", {31'd0, busy}, 0);
    chk("idle_ready", {31'd0, bus.req_ready}, 1);

    // Pure add 0000 -> 0101.
    push(4'b0101, 1'b0, 1'b1, 8, 0);
    send(4'b0101, 1'b1);
    drain(1'b1);

    // 0101 -> 0011: drop to 0001, dead time, add to 0011.
    push(4'b0001, 1'b1, 1'b1, 8, 0);
    push(4'b0011, 1'b0, 1'b1, 0, 16);
    send(4'b0011, 1'b1);
    drain(1'b1);

    // Swap 0011 -> 0110.
    push(4'b0010, 1'b1, 1'b1, 8, 0);
    push(4'b0110, 1'b0, 1'b1, 0, 16);
    send(4'b0110, 1'b1);
    drain(1'b1);

    // 0110 -> 0111 add, then pure drop 0111 -> 0001, then same-value request.
    push(4'b0111, 1'b0, 1'b1, 8, 0);
    send(4'b0111, 1'b1);
    drain(1'b1);
    push(4'b0001, 1'b0, 1'b1, 8, 0);
    send(4'b0001, 1'b1);
    drain(1'b1);
    send(4'b0001, 1'b0);
    repeat (10) step();
    chk("noop_state", {28'd0, state}, 4'b0001);
    chk("noop_busy", {31'd0, busy}, 0);

    // 0001 -> 0011, then all_off during DEAD of 0011 -> 1100.
    push(4'b0011, 1'b0, 1'b1, 8, 0);
    send(4'b0011, 1'b1);
    drain(1'b1);
    push(4'b0000, 1'b1, 1'b1, 8, 0);
    send(4'b1100, 1'b1);
    drain(1'b0);
    repeat (3) step();
    chk("in_dead_busy", {31'd0, busy}, 1);
    all_off = 1'b1;
    #1;
    chk("alloff_ready_low", {31'd0, bus.req_ready}, 0);
    step();
    chk("alloff_state", {28'd0, state}, 0);
    chk("alloff_busy", {31'd0, busy}, 0);
    repeat (20) step();
    chk("alloff_ready_held", {31'd0, bus.req_ready}, 0);
    all_off = 1'b0;
    repeat (24) step();
    chk("post_alloff_state", {28'd0, state}, 0);
    chk("post_alloff_busy", {31'd0, busy}, 0);
    chk("post_alloff_ready", {31'd0, bus.req_ready}, 1);

    // all_off from a non-zero idle state clears on the very next clk.
    push(4'b0011, 1'b0, 1'b1, 8, 0);
    send(4'b0011, 1'b1);
    drain(1'b1);
    step();
    push(4'b0000, 1'b0, 1'b0, 1, 0);
    mark_cyc = cyc;
    all_off  = 1'b1;
    step();
    all_off = 1'b0;
    drain(1'b1);

    // Reset during DEAD of 0011 -> 0110.
    push(4'b0011, 1'b0, 1'b1, 8, 0);
    send(4'b0011, 1'b1);
    drain(1'b1);
    push(4'b0010, 1'b1, 1'b1, 8, 0);
    send(4'b0110, 1'b1);
    drain(1'b0);
    repeat (4) step();
    push(4'b0000, 1'b0, 1'b0, 0, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_clk", {31'd0, clk500khz}, 0);
    chk("async_rst_state", {28'd0, state}, 0);
    chk("async_rst_busy", {31'd0, busy}, 0);
    chk("async_rst_ready", {31'd0, bus.req_ready}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      step();
      chk("div_after_rerelease", {31'd0, clk500khz}, (n / 4) % 2);
    end
    repeat (24) step();
    chk("no_resume_state", {28'd0, state}, 0);
    chk("no_resume_busy", {31'd0, busy}, 0);
    chk("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
